// File: rtl/pattern_stepper.sv
// pattern_stepper: steps a W-bit output through binary, gray, johnson or
// one-hot sequences, advanced either by an internal period timer (auto) or
// by a synchronized trigger edge (manual). All flops run on clk; steps are
// single-cycle enables.
module pattern_stepper #(
  parameter int W  = 4,
  parameter int PW = 9
) (
  input  logic          clk,
  input  logic          CR,
  input  logic          mode,
  input  logic          trigger,
  input  logic          dir,
  input  logic [1:0]    pattern,
  input  logic [PW-1:0] period,
  input  logic          pause,
  output logic [W-1:0]  data,
  output logic          step,
  output logic          wrap
);

  localparam logic [W-1:0]  L_ONE_W  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] L_ONE_PW = {{(PW-1){1'b0}}, 1'b1};

  logic [W-1:0]  r_data;
  logic [W-1:0]  r_idx;
  logic          r_step;
  logic          r_wrap;
  logic [1:0]    r_pat;
  logic [PW-1:0] r_timer;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_sync3;

  logic          w_reload;
  logic          w_edge;
  logic          w_tick;
  logic          w_man_step;
  logic          w_step_en;
  logic [PW-1:0] w_period_m1;
  logic [W-1:0]  w_data_nxt;
  logic [W-1:0]  w_idx_nxt;
  logic [W-1:0]  w_start_cur;
  logic [W-1:0]  w_start_new;

  // Start value of the active pattern (wrap compare) and of the requested one (reload).
  always_comb begin
    w_start_cur = (r_pat   == 2'b11) ? L_ONE_W : '0;
    w_start_new = (pattern == 2'b11) ? L_ONE_W : '0;
  end

  // Step sources: timer tick in auto mode, synchronized trigger edge in manual.
  // A pending reload swallows any coincident step.
  always_comb begin
    w_reload    = (pattern != r_pat);
    w_edge      = r_sync2 & ~r_sync3;
    w_period_m1 = period - L_ONE_PW;
    w_tick      = ~mode & (period != '0) & ~pause & (r_timer >= w_period_m1);
    w_man_step  = mode & w_edge & ~pause;
    w_step_en   = (w_tick | w_man_step) & ~w_reload;
  end

  // Next value of the sequence for the currently active pattern and direction.
  always_comb begin
    w_idx_nxt  = r_idx;
    w_data_nxt = r_data;
    case (r_pat)
      2'b00: w_data_nxt = dir ? (r_data - L_ONE_W) : (r_data + L_ONE_W);
      2'b01: begin
        w_idx_nxt  = dir ? (r_idx - L_ONE_W) : (r_idx + L_ONE_W);
        w_data_nxt = w_idx_nxt ^ (w_idx_nxt >> 1);
      end
      2'b10: w_data_nxt = dir ? {~r_data[0], r_data[W-1:1]}
                              : {r_data[W-2:0], ~r_data[W-1]};
      2'b11: w_data_nxt = dir ? {r_data[0], r_data[W-1:1]}
                              : {r_data[W-2:0], r_data[W-1]};
      default: w_data_nxt = r_data;
    endcase
  end

  // Trigger synchronizer (two flops) followed by the edge-detect history flop.
  always_ff @(posedge clk or posedge CR) begin
    if (CR) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= trigger;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Period timer: counts up to period-1 then wraps; held at 0 when not auto-stepping.
  always_ff @(posedge clk or posedge CR) begin
    if (CR) begin
      r_timer <= '0;
    end else if (w_reload || mode || (period == '0)) begin
      r_timer <= '0;
    end else if (pause) begin
      r_timer <= r_timer;
    end else if (w_tick) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + L_ONE_PW;
    end
  end

  // Data/index/pattern-copy register with reload, step and wrap pulse generation.
  always_ff @(posedge clk or posedge CR) begin
    if (CR) begin
      r_data <= '0;
      r_idx  <= '0;
      r_pat  <= 2'b00;
      r_step <= 1'b0;
      r_wrap <= 1'b0;
    end else if (w_reload) begin
      r_pat  <= pattern;
      r_data <= w_start_new;
      r_idx  <= '0;
      r_step <= 1'b0;
      r_wrap <= 1'b0;
    end else if (w_step_en) begin
      r_data <= w_data_nxt;
      r_idx  <= w_idx_nxt;
      r_step <= 1'b1;
      r_wrap <= (w_data_nxt == w_start_cur);
    end else begin
      r_step <= 1'b0;
      r_wrap <= 1'b0;
    end
  end

  assign data = r_data;
  assign step = r_step;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_pattern_stepper.sv
// Directed bench for pattern_stepper (W=4, PW=9) with hand-computed expectations.
module tb_pattern_stepper;

  logic       clk;
  logic       CR;
  logic       mode;
  logic       trigger;
  logic       dir;
  logic [1:0] pattern;
  logic [8:0] period;
  logic       pause;
  logic [3:0] data;
  logic       step;
  logic       wrap;

  int n_tests;
  int n_fail;

  pattern_stepper #(.W(4), .PW(9)) dut (
    .clk     (clk),
    .CR      (CR),
    .mode    (mode),
    .trigger (trigger),
    .dir     (dir),
    .pattern (pattern),
    .period  (period),
    .pause   (pause),
    .data    (data),
    .step    (step),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  // One manual step: data must stay put for two clocks and update on the third.
  task automatic trig_step(input string tag, input logic [3:0] prev_d,
                           input logic [3:0] exp_d, input logic exp_w);
    trigger = 1'b1;
    clk_step();
    check({tag, "_c1_step"}, step, 0);
    clk_step();
    check({tag, "_c2_data"}, data, prev_d);
    clk_step();
    check({tag, "_data"}, data, exp_d);
    check({tag, "_step"}, step, 1);
    check({tag, "_wrap"}, wrap, exp_w);
    trigger = 1'b0;
    repeat (3) clk_step();
  endtask

  logic [3:0] gray_exp [4];
  logic [3:0] john_exp [10];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    gray_exp = '{4'b0001, 4'b0011, 4'b0010, 4'b0110};
    john_exp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                 4'b1100, 4'b1000, 4'b0000, 4'b1000, 4'b1100};

    // Binary auto, period 3
    CR = 1'b1; mode = 1'b0; trigger = 1'b0; dir = 1'b0;
    pattern = 2'b00; period = 9'd3; pause = 1'b0;
    repeat (2) clk_step();
    check("rst_data", data, 0);
    check("rst_step", step, 0);
    check("rst_wrap", wrap, 0);
    CR = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      clk_step();
      check("bin_c1_step", step, 0);
      clk_step();
      check("bin_c2_step", step, 0);
      check("bin_c2_data", data, (k - 1) % 16);
      clk_step();
      check("bin_data", data, k % 16);
      check("bin_step", step, 1);
      check("bin_wrap", wrap, (k == 16) ? 1 : 0);
    end

    // Gray manual, reload after reset
    CR = 1'b1; pattern = 2'b01; mode = 1'b1; period = 9'd0;
    #2;
    CR = 1'b0;
    clk_step();
    check("gray_reload_data", data, 0);
    check("gray_reload_step", step, 0);
    for (int i = 0; i < 4; i++)
      trig_step("gray", (i == 0) ? 4'b0000 : gray_exp[i-1], gray_exp[i], 1'b0);

    // Johnson: 8 forward steps then 2 reverse
    pattern = 2'b10;
    clk_step();
    check("john_reload_data", data, 0);
    check("john_reload_step", step, 0);
    dir = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) dir = 1'b1;
      trig_step("john", (i == 0) ? 4'b0000 : john_exp[i-1], john_exp[i], (i == 7));
    end

    // One-hot after reset, reverse step, reload on a tick cycle
    CR = 1'b1; pattern = 2'b11; dir = 1'b0;
    #2;
    CR = 1'b0;
    clk_step();
    check("oh_reload_data", data, 4'b0001);
    check("oh_reload_step", step, 0);
    dir = 1'b1;
    trig_step("oh_rev", 4'b0001, 4'b1000, 1'b0);
    mode = 1'b0; period = 9'd2; dir = 1'b0;
    clk_step();
    check("oh_t1_step", step, 0);
    pattern = 2'b00;
    clk_step();
    check("sw_data", data, 0);
    check("sw_step", step, 0);
    check("sw_wrap", wrap, 0);
    clk_step();
    check("sw_hold_data", data, 0);
    check("sw_hold_step", step, 0);
    clk_step();
    check("sw_next_data", data, 1);
    check("sw_next_step", step, 1);

    // Pause mid-count, then period lowered below timer
    CR = 1'b1; pattern = 2'b00; period = 9'd5; mode = 1'b0; dir = 1'b0;
    #2;
    CR = 1'b0;
    repeat (3) begin
      clk_step();
      check("p5_pre_step", step, 0);
    end
    pause = 1'b1;
    repeat (10) begin
      clk_step();
      check("pause_data", data, 0);
      check("pause_step", step, 0);
    end
    pause = 1'b0;
    clk_step();
    check("resume_t4_step", step, 0);
    check("resume_t4_data", data, 0);
    clk_step();
    check("resume_tick_data", data, 1);
    check("resume_tick_step", step, 1);
    repeat (3) begin
      clk_step();
      check("p5_count_step", step, 0);
    end
    period = 9'd1;
    for (int k = 2; k <= 4; k++) begin
      clk_step();
      check("p1_data", data, k);
      check("p1_step", step, 1);
    end

    // Reset in the middle of trigger synchronization
    mode = 1'b1; period = 9'd0;
    clk_step();
    check("cr_pre_data", data, 4);
    trigger = 1'b1;
    clk_step();
    clk_step();
    CR = 1'b1;
    #1;
    check("cr_async_data", data, 0);
    check("cr_async_step", step, 0);
    trigger = 1'b0;
    #2;
    CR = 1'b0;
    repeat (4) begin
      clk_step();
      check("cr_post_data", data, 0);
      check("cr_post_step", step, 0);
    end
    trig_step("cr_after", 4'b0000, 4'b0001, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_stepper.md
PATTERN_STEPPER -- requirements
Module: pattern_stepper

Interface
REQ-001 SHALL have parameter W, default 4, giving the data/state width (W >= 2).
REQ-002 SHALL have parameter PW, default 9, giving the auto-step period register width.
REQ-003 SHALL have port clk, input, 1, the single system clock; all flops use its rising edge.
REQ-004 SHALL have port CR, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port mode, input, 1: 0 = auto (timer-driven), 1 = manual (trigger-driven).
REQ-006 SHALL have port trigger, input, 1, asynchronous manual step request; rising edge is the request.
REQ-007 SHALL have port dir, input, 1: 0 = forward, 1 = reverse.
REQ-008 SHALL have port pattern, input, 2: 00 binary, 01 gray, 10 johnson, 11 one-hot.
REQ-009 SHALL have port period, input, PW, auto-step period in clk cycles; 0 = auto stepping stopped.
REQ-010 SHALL have port pause, input, 1, freezes timer and suppresses all steps while high.
REQ-011 SHALL have port data, output, W, registered current state.
REQ-012 SHALL have port step, output, 1, registered one-cycle pulse in the cycle data takes a stepped value.
REQ-013 SHALL have port wrap, output, 1, registered one-cycle pulse, coincident with step, when the new data equals the pattern start value.

Function
REQ-014 SHALL derive steps only as single-cycle clock enables; no signal other than clk SHALL clock any flop.
REQ-015 Start values SHALL be: binary 0, gray 0, johnson 0, one-hot 1 (LSB set).
REQ-016 Binary SHALL step data +1 (forward) or -1 (reverse) modulo 2^W.
REQ-017 Gray SHALL keep an internal W-bit index stepped +/-1 modulo 2^W, with data = idx XOR (idx >> 1), registered together with idx.
REQ-018 Johnson forward SHALL shift left, inserting ~data[W-1] at bit 0; reverse SHALL shift right, inserting ~data[0] at bit W-1; cycle length 2W.
REQ-019 One-hot forward SHALL rotate left by 1; reverse SHALL rotate right by 1; cycle length W.
REQ-020 Auto mode, period != 0, pause low: the timer SHALL count 0..period-1, and a tick SHALL fire on the cycle when timer >= period-1, after which the timer SHALL return to 0, giving one step every period cycles.
REQ-021 If period is lowered below the current timer value, the tick SHALL fire on the next cycle (the >= rule).
REQ-022 The timer SHALL be held at 0 whenever mode = 1 or period = 0.
REQ-023 Manual mode: trigger SHALL pass through a 2-flop synchronizer plus a 1-flop edge detector; data SHALL update on the 3rd rising clk after trigger rises, with one step per rising edge.
REQ-024 Trigger edges in auto mode, and edges detected while pause is high, SHALL be discarded and never queued.
REQ-025 While pause is high, the timer and data SHALL hold, and step and wrap SHALL stay 0.
REQ-026 A registered copy of pattern SHALL be kept; when pattern differs from it, the next clk SHALL load the new start value into data (and 0 into idx), reset the timer, and update the copy, with step = 0 and wrap = 0 that cycle.
REQ-027 A pattern reload SHALL take priority over a coincident tick or trigger edge; that step is lost.
REQ-028 dir SHALL be sampled on the step cycle only; changing dir between steps SHALL reverse the sequence from the current value.

Reset
REQ-029 On CR high, the block SHALL immediately and asynchronously set data = 0, idx = 0, timer = 0, step = 0, wrap = 0, synchronizer/edge flops = 0, and the pattern copy = 00.
REQ-030 After CR deasserts with pattern != 00, the first clk SHALL perform the REQ-026 reload (e.g. one-hot gives data = 0001).
REQ-031 CR asserted mid-count or mid-synchronization SHALL discard all pending ticks and edges.

Verification
REQ-032 Bench SHALL cover: W=4, binary, auto, period=3, dir=0 -> data 0,1,2,... changing every 3 clks; step pulses every 3rd cycle; wrap when data returns 0 after 15.
REQ-033 Bench SHALL cover: gray, manual, 4 trigger pulses -> data 0000,0001,0011,0010,0110, each update on the 3rd clk after the trigger rises.
REQ-034 Bench SHALL cover: johnson, dir=0, 8 steps then dir=1 for 2 steps -> 0000,0001,0011,0111,1111,1110,1100,1000,0000 (wrap), then 1000,1100.
REQ-035 Bench SHALL cover: one-hot after reset -> data 0001 after the first clk; dir=1 step -> 1000; pattern switched to binary on a tick cycle -> data 0000, step = 0, no advance.
REQ-036 Bench SHALL cover: auto, period=5, pause high for 10 cycles mid-count -> data frozen, the timer resumes its count afterwards; period changed 5 -> 1 while timer = 3 -> tick on the next cycle, then every cycle.
REQ-037 Bench SHALL cover: CR pulsed between trigger rise and the 3rd clk -> no step occurs, and data = 0 immediately.
